// File: rtl/counter_seq_checker_pkg.sv
// Shared defaults and state encoding for the counter sequence checker.
// Imported by the checker top and its next-value model.
package counter_seq_checker_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LOW   = 10;
    localparam int DEF_HIGH  = 40;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } chk_state_t;

endpackage

// File: rtl/counter_seq_checker_next_model.sv
// Combinational next-value model of the bounded up/down counter.
// Out-of-range values return to LOW; otherwise load, then count.
module counter_next_model
    import counter_seq_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LOW   = DEF_LOW,
    parameter int HIGH  = DEF_HIGH
) (
    input  logic [WIDTH-1:0] c,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             u_d,
    output logic [WIDTH-1:0] nxt
);

    localparam logic [WIDTH-1:0] LOW_W  = WIDTH'(LOW);
    localparam logic [WIDTH-1:0] HIGH_W = WIDTH'(HIGH);

    // Bounds first, then load, then direction.
    always_comb begin
        nxt = c;
        if (c < LOW_W || c >= HIGH_W) begin
            nxt = LOW_W;
        end else if (load) begin
            nxt = data;
        end else if (u_d) begin
            nxt = c + WIDTH'(1);
        end else begin
            nxt = c - WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_seq_checker.sv
// Tracks an observed counter against its next-value model and
// flags sequence breaks, out-of-range values and HIGH-to-LOW wraps.
module counter_seq_checker
    import counter_seq_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LOW   = DEF_LOW,
    parameter int HIGH  = DEF_HIGH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] count,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             u_d,
    output logic             locked,
    output logic [WIDTH-1:0] expected,
    output logic             seq_err,
    output logic             range_err,
    output logic             wrap,
    output logic [7:0]       err_cnt,
    output logic [15:0]      wrap_cnt
);

    localparam logic [WIDTH-1:0] LOW_W  = WIDTH'(LOW);
    localparam logic [WIDTH-1:0] HIGH_W = WIDTH'(HIGH);

    chk_state_t       state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] model_nxt;
    logic             seq_d, range_d, wrap_d;
    logic [7:0]       errc_d;
    logic [15:0]      wrapc_d;

    counter_next_model #(
        .WIDTH (WIDTH),
        .LOW   (LOW),
        .HIGH  (HIGH)
    ) u_model (
        .c    (count),
        .load (load),
        .data (data),
        .u_d  (u_d),
        .nxt  (model_nxt)
    );

    // Next state, next expectation and per-sample flags.
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        prev_d  = prev_q;
        seq_d   = 1'b0;
        range_d = 1'b0;
        wrap_d  = 1'b0;
        errc_d  = err_cnt;
        wrapc_d = wrap_cnt;
        if (valid) begin
            range_d = (count < LOW_W) || (count > HIGH_W);
            exp_d   = model_nxt;
            prev_d  = count;
            state_d = LOCKED;
            unique case (state_q)
                UNLOCKED: begin
                end
                LOCKED: begin
                    if (count != exp_q) begin
                        seq_d = 1'b1;
                        if (err_cnt != 8'hFF) begin
                            errc_d = err_cnt + 8'd1;
                        end
                    end else if (count == LOW_W && prev_q == HIGH_W) begin
                        wrap_d  = 1'b1;
                        wrapc_d = wrap_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end else begin
            state_d = UNLOCKED;
        end
    end

    // All state and outputs registered; reset wins over a sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UNLOCKED;
            exp_q     <= '0;
            prev_q    <= '0;
            seq_err   <= 1'b0;
            range_err <= 1'b0;
            wrap      <= 1'b0;
            err_cnt   <= '0;
            wrap_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            prev_q    <= prev_d;
            seq_err   <= seq_d;
            range_err <= range_d;
            wrap      <= wrap_d;
            err_cnt   <= errc_d;
            wrap_cnt  <= wrapc_d;
        end
    end

    assign locked   = (state_q == LOCKED);
    assign expected = exp_q;

endmodule
